// File: rtl/fft_pkg.sv
// Shared types and default widths for the FFT complex add/subtract datapath.
package fft_pkg;

  typedef enum logic [1:0] {
    ADD    = 2'd0,
    SUB    = 2'd1,
    RSUB   = 2'd2,
    ADD_MJ = 2'd3
  } caddsub_mode_e;

  localparam int DEF_IN_WIDTH  = 16;
  localparam int DEF_OUT_WIDTH = 16;
  localparam int DEF_MAX_SHIFT = 3;

endpackage

// File: rtl/fft_sat_shift.sv
// Arithmetic right shift (optionally rounding half-up) followed by saturation
// to OUT_W bits; rounding is enabled by macro FFT_CADDSUB_ROUND_EN.
module fft_sat_shift #(
  parameter int IN_W      = 17,
  parameter int OUT_W     = 16,
  parameter int MAX_SHIFT = 3,
  parameter int SH_W      = $clog2(MAX_SHIFT + 1)
) (
  input  logic signed [IN_W-1:0]  i_data,
  input  logic        [SH_W-1:0]  i_shift,
  output logic        [OUT_W-1:0] o_data,
  output logic                    o_sat
);

  // One guard bit so the rounding bias can never wrap.
  localparam int EW = IN_W + 1;
  localparam logic signed [EW-1:0] MAX_V = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_V = ~MAX_V;

  logic        [SH_W-1:0] w_sh;
  logic signed [EW-1:0]   w_ext;
  logic signed [EW-1:0]   w_rnd;
  logic signed [EW-1:0]   w_shf;

  always_comb begin
    w_sh  = (i_shift > SH_W'(MAX_SHIFT)) ? SH_W'(MAX_SHIFT) : i_shift;
    w_ext = {i_data[IN_W-1], i_data};
    w_rnd = w_ext;
`ifdef FFT_CADDSUB_ROUND_EN
    if (w_sh != '0) begin
      w_rnd = w_ext + (EW'(1) << (w_sh - 1'b1));
    end
`endif
    w_shf  = w_rnd >>> w_sh;
    o_sat  = 1'b0;
    o_data = w_shf[OUT_W-1:0];
    if (w_shf > MAX_V) begin
      o_data = MAX_V[OUT_W-1:0];
      o_sat  = 1'b1;
    end else if (w_shf < MIN_V) begin
      o_data = MIN_V[OUT_W-1:0];
      o_sat  = 1'b1;
    end
  end

endmodule

// File: rtl/fft_caddsub_pipe.sv
// Two-stage complex add/sub with per-transaction shift and saturation, valid/ready
// on both sides. Macro FFT_CADDSUB_ROUND_EN selects half-up rounding on the shift.
module fft_caddsub_pipe
  import fft_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int MAX_SHIFT = DEF_MAX_SHIFT,
  localparam int SH_W     = $clog2(MAX_SHIFT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  opa_r,
  input  logic [IN_WIDTH-1:0]  opa_i,
  input  logic [IN_WIDTH-1:0]  opb_r,
  input  logic [IN_WIDTH-1:0]  opb_i,
  input  logic [1:0]           mode,
  input  logic [SH_W-1:0]      shift_amt,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_r,
  output logic [OUT_WIDTH-1:0] out_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 ovf_clr,
  output logic                 ovf_sticky
);

  localparam int FW = IN_WIDTH + 1;

  logic signed [FW-1:0]  w_ar, w_ai, w_br, w_bi;
  logic signed [FW-1:0]  w_sum_r, w_sum_i;
  logic signed [FW-1:0]  r_s1_r, r_s1_i;
  logic [SH_W-1:0]       r_s1_shift;
  logic                  r_s1_valid;
  logic                  r_s2_valid;
  logic [OUT_WIDTH-1:0]  r_out_r, r_out_i;
  logic [OUT_WIDTH-1:0]  w_sat_r_data, w_sat_i_data;
  logic                  w_sat_r, w_sat_i;
  logic                  w_s2_free, w_s1_adv, w_accept;
  logic                  r_ovf;

  always_comb begin
    w_ar    = {opa_r[IN_WIDTH-1], opa_r};
    w_ai    = {opa_i[IN_WIDTH-1], opa_i};
    w_br    = {opb_r[IN_WIDTH-1], opb_r};
    w_bi    = {opb_i[IN_WIDTH-1], opb_i};
    w_sum_r = w_ar + w_br;
    w_sum_i = w_ai + w_bi;
    case (caddsub_mode_e'(mode))
      SUB: begin
        w_sum_r = w_ar - w_br;
        w_sum_i = w_ai - w_bi;
      end
      RSUB: begin
        w_sum_r = w_br - w_ar;
        w_sum_i = w_bi - w_ai;
      end
      ADD_MJ: begin
        w_sum_r = w_ar + w_bi;
        w_sum_i = w_ai - w_br;
      end
      default: ;
    endcase
  end

  // Stage 1 may refill while stage 2 stalls, as long as it is empty itself.
  assign w_s2_free = !r_s2_valid || out_ready;
  assign in_ready  = !r_s2_valid || out_ready || !r_s1_valid;
  assign w_accept  = in_valid && in_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_r     <= '0;
      r_s1_i     <= '0;
      r_s1_shift <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_r     <= w_sum_r;
      r_s1_i     <= w_sum_i;
      r_s1_shift <= shift_amt;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  fft_sat_shift #(
    .IN_W      (FW),
    .OUT_W     (OUT_WIDTH),
    .MAX_SHIFT (MAX_SHIFT),
    .SH_W      (SH_W)
  ) u_sat_r (
    .i_data  (r_s1_r),
    .i_shift (r_s1_shift),
    .o_data  (w_sat_r_data),
    .o_sat   (w_sat_r)
  );

  fft_sat_shift #(
    .IN_W      (FW),
    .OUT_W     (OUT_WIDTH),
    .MAX_SHIFT (MAX_SHIFT),
    .SH_W      (SH_W)
  ) u_sat_i (
    .i_data  (r_s1_i),
    .i_shift (r_s1_shift),
    .o_data  (w_sat_i_data),
    .o_sat   (w_sat_i)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_out_r    <= '0;
      r_out_i    <= '0;
    end else if (w_s2_free) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_r <= w_sat_r_data;
        r_out_i <= w_sat_i_data;
      end
    end
  end

  // A new saturation wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_s1_adv && (w_sat_r || w_sat_i)) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign out_r      = r_out_r;
  assign out_i      = r_out_i;
  assign out_valid  = r_s2_valid;
  assign ovf_sticky = r_ovf;

endmodule

// File: tb/tb_fft_caddsub_pipe.sv
// Self-checking bench for fft_caddsub_pipe against a plain-arithmetic reference
// model; honours FFT_CADDSUB_ROUND_EN when the design is built with it.
module tb_fft_caddsub_pipe;

  localparam int OW = 16;
  localparam int MS = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] opa_r, opa_i, opb_r, opb_i;
  logic [1:0]  mode;
  logic [1:0]  shift_amt;
  logic        in_valid, in_ready;
  logic [15:0] out_r, out_i;
  logic        out_valid, out_ready;
  logic        ovf_clr, ovf_sticky;

  int vectors    = 0;
  int miscompares = 0;
  int qr[$];
  int qi[$];

  fft_caddsub_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opa_r      (opa_r),
    .opa_i      (opa_i),
    .opb_r      (opb_r),
    .opb_i      (opb_i),
    .mode       (mode),
    .shift_amt  (shift_amt),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_r      (out_r),
    .out_i      (out_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ovf_clr    (ovf_clr),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  // Reference: shift the exact integer result, then clamp to the output range.
  function automatic int shr_sat(input int x, input int sh);
    int s;
    int y;
    s = (sh > MS) ? MS : sh;
    y = x;
`ifdef FFT_CADDSUB_ROUND_EN
    if (s > 0) y = y + (1 << (s - 1));
`endif
    y = y >>> s;
    if (y > (1 << (OW - 1)) - 1) y = (1 << (OW - 1)) - 1;
    if (y < -(1 << (OW - 1))) y = -(1 << (OW - 1));
    return y;
  endfunction

  function automatic void model(input int m, input int ar, input int ai, input int br,
                                input int bi, input int sh, output int er, output int ei);
    int fr;
    int fi;
    case (m)
      0: begin fr = ar + br; fi = ai + bi; end
      1: begin fr = ar - br; fi = ai - bi; end
      2: begin fr = br - ar; fi = bi - ai; end
      default: begin fr = ar + bi; fi = ai - br; end
    endcase
    er = shr_sat(fr, sh);
    ei = shr_sat(fi, sh);
  endfunction

  task automatic drive(input int m, input int ar, input int ai, input int br,
                       input int bi, input int sh);
    mode      = 2'(m);
    opa_r     = 16'(ar);
    opa_i     = 16'(ai);
    opb_r     = 16'(br);
    opb_i     = 16'(bi);
    shift_amt = 2'(sh);
  endtask

  task automatic rand_txn(output int m, output int ar, output int ai, output int br,
                          output int bi, output int sh);
    m  = int'($urandom_range(0, 3));
    ar = int'($urandom_range(0, 65535)) - 32768;
    ai = int'($urandom_range(0, 65535)) - 32768;
    br = int'($urandom_range(0, 65535)) - 32768;
    bi = int'($urandom_range(0, 65535)) - 32768;
    sh = int'($urandom_range(0, 3));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ovf_sticky !== 1'b0 || out_r !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL por_state: got valid=%b ready=%b ovf=%b out_r=%0d want 0 1 0 0",
               out_valid, in_ready, ovf_sticky, out_r);
    end
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    drive(0, 32767, 0, 1, 0, 0);
    in_valid = 1'b1;
    @(negedge clk);
    drive(0, 1, 1, 1, 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL full_stall: got ready=%b valid=%b want 0 1", in_ready, out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ovf_sticky !== 1'b0 || out_r !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL midstream_reset: got valid=%b ready=%b ovf=%b out_r=%0d want 0 1 0 0",
               out_valid, in_ready, ovf_sticky, out_r);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(0, 1, -4, 2, 1, 0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stale_after_reset: got valid=%b want 0", out_valid);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_r !== 16'd3 || out_i !== 16'hFFFD) begin
      miscompares++;
      $display("[TB] FAIL first_accept: got valid=%b (%0d,%0d) want 1 (3,-3)",
               out_valid, $signed(out_r), $signed(out_i));
    end
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL drain_after_reset: got valid=%b want 0", out_valid);
      end
    end
  endtask

  task automatic test_modes();
    int ter[4];
    int tei[4];
    ter = '{130, 70, -70, 120};
    tei = '{-30, -70, 70, -80};
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      drive(m, 100, -50, 30, 20, 0);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL mode%0d_latency: got valid=%b one cycle after accept want 0", m, out_valid);
      end
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_r !== 16'(ter[m]) || out_i !== 16'(tei[m])) begin
        miscompares++;
        $display("[TB] FAIL mode%0d: got valid=%b (%0d,%0d) want 1 (%0d,%0d)",
                 m, out_valid, $signed(out_r), $signed(out_i), ter[m], tei[m]);
      end
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (ovf_sticky !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ovf_initial: got %b want 0", ovf_sticky);
    end
    drive(0, 32767, -32768, 1, -1, 0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_r !== 16'h7FFF || out_i !== 16'h8000) begin
      miscompares++;
      $display("[TB] FAIL sat_value: got valid=%b (%0d,%0d) want 1 (32767,-32768)",
               out_valid, $signed(out_r), $signed(out_i));
    end
    @(negedge clk);
    vectors++;
    if (ovf_sticky !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ovf_set: got %b want 1", ovf_sticky);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    vectors++;
    if (ovf_sticky !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ovf_clear: got %b want 0", ovf_sticky);
    end
    ovf_clr = 1'b1;
    drive(1, -32768, 0, 5, 0, 0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (ovf_sticky !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ovf_set_wins: got %b want 1", ovf_sticky);
    end
    @(negedge clk);
    ovf_clr = 1'b0;
    vectors++;
    if (ovf_sticky !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ovf_clear_after_set: got %b want 0", ovf_sticky);
    end
  endtask

  task automatic test_shift_round();
    int sa[3][6];
    int er, ei;
    sa = '{'{0, 5, -5, 0, 0, 1}, '{1, 100, -100, 3, 0, 3}, '{3, -9, 7, 4, 2, 2}};
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(sa[k][0], sa[k][1], sa[k][2], sa[k][3], sa[k][4], sa[k][5]);
      model(sa[k][0], sa[k][1], sa[k][2], sa[k][3], sa[k][4], sa[k][5], er, ei);
      if (k == 0) begin
`ifdef FFT_CADDSUB_ROUND_EN
        er = 3; ei = -2;
`else
        er = 2; ei = -3;
`endif
      end
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_r !== 16'(er) || out_i !== 16'(ei)) begin
        miscompares++;
        $display("[TB] FAIL shift%0d: got valid=%b (%0d,%0d) want 1 (%0d,%0d)",
                 k, out_valid, $signed(out_r), $signed(out_i), er, ei);
      end
    end
  endtask

  task automatic test_backpressure();
    int sent, got, er, ei;
    int m, ar, ai, br, bi, sh;
    bit have, prev_stall;
    logic [15:0] hold_r, hold_i;
    sent = 0; got = 0; have = 0; prev_stall = 0;
    hold_r = '0; hold_i = '0;
    qr.delete(); qi.delete();
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 20) begin
        if (!have) begin
          rand_txn(m, ar, ai, br, bi, sh);
          have = 1;
        end
        drive(m, ar, ai, br, bi, sh);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        vectors++;
        if (out_valid !== 1'b1 || out_r !== hold_r || out_i !== hold_i) begin
          miscompares++;
          $display("[TB] FAIL bp_stable: got valid=%b (%h,%h) want 1 (%h,%h)",
                   out_valid, out_r, out_i, hold_r, hold_i);
        end
      end
      vectors++;
      if (in_ready !== !(qr.size() == 2 && !out_ready)) begin
        miscompares++;
        $display("[TB] FAIL bp_in_ready: got %b want %b (in flight %0d, out_ready %b)",
                 in_ready, !(qr.size() == 2 && !out_ready), qr.size(), out_ready);
      end
      if (qr.size() == 0) begin
        vectors++;
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL bp_phantom: got valid=%b with nothing in flight want 0", out_valid);
        end
      end
      if (out_valid === 1'b1 && out_ready && qr.size() > 0) begin
        er = qr.pop_front();
        ei = qi.pop_front();
        vectors++;
        if (out_r !== 16'(er) || out_i !== 16'(ei)) begin
          miscompares++;
          $display("[TB] FAIL bp_data[%0d]: got (%0d,%0d) want (%0d,%0d)",
                   got, $signed(out_r), $signed(out_i), er, ei);
        end
        got++;
      end
      if (in_valid && in_ready === 1'b1) begin
        model(m, ar, ai, br, bi, sh, er, ei);
        qr.push_back(er);
        qi.push_back(ei);
        sent++;
        have = 0;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      hold_r = out_r;
      hold_i = out_i;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (got != 20) begin
      miscompares++;
      $display("[TB] FAIL bp_count: got %0d results want 20", got);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_throughput();
    int m, ar, ai, br, bi, sh, er, ei;
    bit exp_v;
    qr.delete(); qi.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 104; c++) begin
      @(negedge clk);
      if (c < 100) begin
        rand_txn(m, ar, ai, br, bi, sh);
        drive(m, ar, ai, br, bi, sh);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_v = (c >= 2 && c <= 101);
      vectors++;
      if (out_valid !== exp_v || (c < 100 && in_ready !== 1'b1)) begin
        miscompares++;
        $display("[TB] FAIL tput_valid[%0d]: got valid=%b ready=%b want valid=%b ready=1",
                 c, out_valid, in_ready, exp_v);
      end
      if (out_valid === 1'b1 && qr.size() > 0) begin
        er = qr.pop_front();
        ei = qi.pop_front();
        vectors++;
        if (out_r !== 16'(er) || out_i !== 16'(ei)) begin
          miscompares++;
          $display("[TB] FAIL tput_data[%0d]: got (%0d,%0d) want (%0d,%0d)",
                   c, $signed(out_r), $signed(out_i), er, ei);
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        model(m, ar, ai, br, bi, sh, er, ei);
        qr.push_back(er);
        qi.push_back(ei);
      end
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_saturation();
    test_shift_round();
    test_backpressure();
    test_throughput();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fft_caddsub_pipe.md
FFT_CADDSUB_PIPE -- requirements
Module: fft_caddsub_pipe

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16, bit width of each real/imag input component (two's complement).
REQ-002 SHALL have parameter OUT_WIDTH, default 16, bit width of each real/imag output component; legal range 2..IN_WIDTH+1.
REQ-003 SHALL have parameter MAX_SHIFT, default 3, largest legal right-shift amount.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports opa_r, opa_i, opb_r, opb_i, input, IN_WIDTH each, operand components.
REQ-007 SHALL have port mode, input, 2, operation select per transaction (fft_pkg::caddsub_mode_e).
REQ-008 SHALL have port shift_amt, input, $clog2(MAX_SHIFT+1), per-transaction right shift.
REQ-009 SHALL have ports in_valid (input, 1) and in_ready (output, 1), input handshake.
REQ-010 SHALL have ports out_r, out_i, output, OUT_WIDTH each, result components.
REQ-011 SHALL have ports out_valid (output, 1) and out_ready (input, 1), output handshake.
REQ-012 SHALL have port ovf_clr (input, 1), synchronous clear of ovf_sticky.
REQ-013 SHALL have port ovf_sticky (output, 1), set when any result component saturated.

Function
REQ-014 SHALL compute, at IN_WIDTH+1 bits without loss: mode 0 a+b; mode 1 a-b; mode 2 b-a; mode 3 a+(-j)b, i.e. r=ar+bi, i=ai-br.
REQ-015 SHALL arithmetic-right-shift each full-precision component by shift_amt; shift_amt>MAX_SHIFT SHALL be treated as MAX_SHIFT.
REQ-016 SHALL, after shift, saturate each component independently to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-017 SHALL be a two-stage pipeline: stage 1 add/sub register, stage 2 shift/round/saturate register; latency exactly 2 cycles with out_ready held high.
REQ-018 SHALL accept a transaction on cycles where in_valid && in_ready; mode and shift_amt SHALL be captured with the operands.
REQ-019 SHALL drive in_ready = !s2_valid || out_ready || !s1_valid (stage 1 may fill while stage 2 holds); each stage advances independently when its downstream slot is free or draining.
REQ-020 SHALL hold out_r, out_i, out_valid stable while out_valid && !out_ready.
REQ-021 SHALL sustain one transaction per cycle with out_ready continuously high; no bubble insertion, no reordering, no loss or duplication under any stall pattern.
REQ-022 SHALL set ovf_sticky the cycle after a saturated result enters stage 2; ovf_clr same cycle as a new saturation SHALL leave ovf_sticky set (set wins).
REQ-023 SHALL ignore operand/mode values when in_valid low; output data when out_valid low is don't-care.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear s1_valid, s2_valid, out_valid, ovf_sticky and out_r/out_i to 0; in_ready SHALL be 1 after reset.
REQ-025 SHALL discard in-flight transactions when reset asserts mid-operation; first post-reset accept occurs on the first clk edge with rst_n high.

Configuration
REQ-026 SHALL support macro FFT_CADDSUB_ROUND_EN: when defined, shift rounds half-up (add 2^(shift_amt-1) before shift, shift_amt>0) prior to saturation; when undefined, shift truncates toward minus infinity; latency unchanged either way.

Structure
REQ-027 SHALL place caddsub_mode_e (ADD, SUB, RSUB, ADD_MJ) and default width constants in shared package fft_pkg.
REQ-028 SHALL implement shift/round/saturate as sub-module fft_sat_shift, one instance per component (real, imag), flagging saturation.

Verification
REQ-029 Reset: assert rst_n=0 mid-stream with 2 in flight -> out_valid=0, ovf_sticky=0, in_ready=1; no stale output after release.
REQ-030 Modes, W=16, shift 0: a=(100,-50), b=(30,20) -> mode0 (130,-30), mode1 (70,-70), mode2 (-70,70), mode3 (120,-80), each 2 cycles after accept.
REQ-031 Saturation: a=(32767,-32768), b=(1,-1), mode0, shift 0 -> (32767,-32768), ovf_sticky=1 next cycle; ovf_clr -> 0.
REQ-032 Shift/round: a=(5,-5), b=(0,0), shift 1 -> (3,-2) with FFT_CADDSUB_ROUND_EN, (2,-3) without.
REQ-033 Backpressure: 20 back-to-back transactions, out_ready random 50% -> all 20 results in order, values stable while stalled, in_ready low only when both stages full and out_ready=0.
REQ-034 Throughput: out_ready=1, in_valid=1 for 100 cycles -> out_valid=1 continuously from cycle 2 to cycle 101.
